// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: tick-paced UART transmitter, LSB first, valid/ready byte input.
// Ports: clk, clr (async high), baud_tick, tx_data/tx_valid/tx_ready, tx, busy.
// Optional parity bit: define UART_TX_PARITY_EN (sense from PARITY_ODD).
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SYNC   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif
    localparam logic [2:0] STOP   = 3'd5;

    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift_q;
    logic [CW-1:0]        cnt_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    assign tx_ready = (state == IDLE);
    assign busy     = !tx_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    // A tick in the accept cycle is deliberately ignored;
                    // SYNC aligns the start bit to a full tick period.
                    if (tx_valid) begin
                        shift_q <= tx_data;
                        cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
                        par_q   <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
                        state   <= SYNC;
                    end
                end
                SYNC: begin
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx      <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (cnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par_q;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            cnt_q <= '0;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx    <= 1'b1;
                        cnt_q <= '0;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tick) begin
                        if (cnt_q == STOP_LAST) begin
                            state <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: random and directed frames vs. a bit-list model.
// Expected line levels come from per-frame bit queues and tick counting.
module tb_uart_tx_serializer;

    localparam int DB = 8;
    localparam int SB = 2;
    localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic          baud_tick;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          busy;

    int n_chk = 0;
    int n_pass = 0;
    int period = 4;
    int ph = 0;
    bit exp_q[$];

    uart_tx_serializer #(
        .DATA_BITS (DB),
        .STOP_BITS (SB),
        .PARITY_ODD(PO)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .baud_tick(baud_tick),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Line levels of one frame, one entry per tick period.
    function automatic void build_frame(input logic [DB-1:0] d);
        bit p;
        exp_q.delete();
        exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < DB; i++) begin
            exp_q.push_back(d[i]);
            p ^= d[i];
        end
        if (PB == 1) exp_q.push_back(p ^ PO[0]);
        for (int i = 0; i < SB; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic step(output bit t);
        baud_tick = (ph == 0);
        t = baud_tick;
        ph = (ph + 1 >= period) ? 0 : ph + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rate(input int p, input int phase);
        period = p;
        ph = phase;
    endtask

    // hold: keep tx_valid high with junk data while busy.
    // abort_j: pulse clr once this many ticks of the frame have passed.
    task automatic send(input logic [DB-1:0] d, input bit hold,
                        input int abort_j);
        bit t;
        int j;
        int n;
        tx_data = d;
        tx_valid = 1'b1;
        chk("ready_before_accept", tx_ready, 1);
        step(t);
        build_frame(d);
        n = exp_q.size();
        if (!hold) tx_valid = 1'b0;
        j = 0;
        chk("busy_after_accept", busy, 1);
        chk("tx_idle_after_accept", tx, 1);
        while (j <= n) begin
            if (hold) tx_data = DB'($urandom);
            step(t);
            if (t) j++;
            if (j <= n) begin
                chk("tx_bit", tx, (j == 0) ? 1 : 32'(exp_q[j-1]));
                chk("ready_low_in_frame", tx_ready, 0);
            end
            if (j == abort_j) begin
                clr = 1'b1;
                #1;
                chk("clr_tx", tx, 1);
                chk("clr_ready", tx_ready, 1);
                chk("clr_busy", busy, 0);
                clr = 1'b0;
                tx_valid = 1'b0;
                return;
            end
        end
        chk("ready_after_stop", tx_ready, 1);
        chk("busy_after_stop", busy, 0);
        chk("tx_after_stop", tx, 1);
    endtask

    task automatic idle(input int cycles);
        bit t;
        tx_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tx_data = DB'($urandom);
            step(t);
            chk("idle_tx", tx, 1);
            chk("idle_ready", tx_ready, 1);
        end
    endtask

    initial begin
        bit hold;
        clr = 1'b1;
        baud_tick = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_ready", tx_ready, 1);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        set_rate(4, 1);
        idle(2);
        send(8'hA5, 1'b0, -1);
        idle(3);

        // back-to-back with tx_valid held through the frame
        set_rate(3, 0);
        send(8'h00, 1'b1, -1);
        send(8'hFF, 1'b0, -1);
        idle(2);

        // reset during bit 3 (start bit is tick 1)
        set_rate(4, 2);
        send(8'h3C, 1'b0, 5);
        send(8'h55, 1'b0, -1);
        idle(2);

        // tick tied high: accept-cycle tick must be ignored
        set_rate(1, 0);
        send(8'h81, 1'b0, -1);
        idle(1);

        for (int k = 0; k < 40; k++) begin
            set_rate($urandom_range(1, 5), 0);
            ph = $urandom_range(0, period - 1);
            hold = ($urandom_range(0, 1) == 1) && (k != 39);
            if (($urandom_range(0, 9) == 0) && !hold) begin
                send(DB'($urandom), 1'b0, $urandom_range(1, 11));
            end else begin
                send(DB'($urandom), hold, -1);
            end
            if (!hold) idle($urandom_range(0, 3));
        end
        tx_valid = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
